// File: rtl/compress_pkg.sv
// rtl/compress_pkg.sv - shared codeword classes, lengths and widths for the word length decoder
package compress_pkg;

  localparam int BUF_W  = 64;
  localparam int WORD_W = 32;
  localparam int FILL_W = 7;

  typedef enum logic [2:0] {
    ENC_00  = 3'd0,
    ENC_01  = 3'd1,
    ENC_100 = 3'd2,
    ENC_101 = 3'd3,
    ENC_110 = 3'd4,
    ENC_111 = 3'd5
  } enc_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [5:0] LEN_00  = 6'd2;
  localparam logic [5:0] LEN_01  = 6'd6;
  localparam logic [5:0] LEN_100 = 6'd12;
  localparam logic [5:0] LEN_101 = 6'd16;
  localparam logic [5:0] LEN_110 = 6'd24;
  localparam logic [5:0] LEN_111 = 6'd34;

  typedef struct packed {
    logic [1:0] pfx_w;
    logic [4:0] pay_w;
    logic [5:0] len;
  } code_info_t;

  function automatic code_info_t code_info(input enc_e enc);
    code_info_t info;
    case (enc)
      ENC_00:  info = '{pfx_w: 2'd2, pay_w: 5'd0,  len: LEN_00};
      ENC_01:  info = '{pfx_w: 2'd2, pay_w: 5'd4,  len: LEN_01};
      ENC_100: info = '{pfx_w: 2'd3, pay_w: 5'd9,  len: LEN_100};
      ENC_101: info = '{pfx_w: 2'd3, pay_w: 5'd13, len: LEN_101};
      ENC_110: info = '{pfx_w: 2'd3, pay_w: 5'd21, len: LEN_110};
      ENC_111: info = '{pfx_w: 2'd3, pay_w: 5'd31, len: LEN_111};
      default: info = '{pfx_w: 2'd2, pay_w: 5'd0,  len: LEN_00};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/word_prefix_decoder.sv
// rtl/word_prefix_decoder.sv - combinational prefix decode of the top three buffer bits
module word_prefix_decoder
  import compress_pkg::*;
(
  input  logic [2:0] i_top,
  output enc_e       o_enc,
  output logic [5:0] o_len,
  output logic [4:0] o_pay_w,
  output logic [1:0] o_pfx_w
);

  code_info_t info;

  always_comb begin
    o_enc = ENC_00;
    casez (i_top)
      3'b00?:  o_enc = ENC_00;
      3'b01?:  o_enc = ENC_01;
      3'b100:  o_enc = ENC_100;
      3'b101:  o_enc = ENC_101;
      3'b110:  o_enc = ENC_110;
      3'b111:  o_enc = ENC_111;
      default: o_enc = ENC_00;
    endcase
    info    = code_info(o_enc);
    o_len   = info.len;
    o_pay_w = info.pay_w;
    o_pfx_w = info.pfx_w;
  end

endmodule

// File: rtl/word_length_decoder.sv
// rtl/word_length_decoder.sv - splits a packed MSB-first stream into prefix-coded codewords
// Optional o_word_count handshake counter with WORD_LENGTH_DECODER_STATS_EN.
module word_length_decoder
  import compress_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_flush,
  output logic [2:0]        o_encoded,
  output logic [5:0]        o_length,
  output logic [31:0]       o_payload,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_done
`ifdef WORD_LENGTH_DECODER_STATS_EN
  ,
  output logic [15:0]       o_word_count
`endif
);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               i_ready_q, i_ready_d;
  logic               o_valid_q, o_valid_d;
  logic [2:0]         enc_q, enc_d;
  logic [5:0]         len_q, len_d;
  logic [31:0]        pay_q, pay_d;

  enc_e               dec_enc;
  logic [5:0]         dec_len;
  logic [4:0]         dec_pay_w;
  logic [1:0]         dec_pfx_w;
  logic [BUF_W-1:0]   after_pfx;
  logic [31:0]        dec_payload;
  logic               have_prefix;
  logic               complete;
  logic               push;
  logic               pop;
  logic [BUF_W-1:0]   buf_shift;
  logic [FILL_W-1:0]  fill_shift;

  word_prefix_decoder u_prefix (
    .i_top   (buf_q[BUF_W-1 -: 3]),
    .o_enc   (dec_enc),
    .o_len   (dec_len),
    .o_pay_w (dec_pay_w),
    .o_pfx_w (dec_pfx_w)
  );

  // A 1xx prefix needs its third bit to be real data before it can be trusted.
  always_comb begin
    have_prefix = buf_q[BUF_W-1] ? (fill_q >= 7'd3) : (fill_q >= 7'd2);
    complete    = have_prefix && (fill_q >= {1'b0, dec_len});
    after_pfx   = buf_q << dec_pfx_w;
    dec_payload = after_pfx[BUF_W-1 -: WORD_W] >> (6'(WORD_W) - {1'b0, dec_pay_w});
  end

  always_comb begin
    push = i_valid && i_ready_q;
    pop  = complete && (!o_valid_q || o_ready) && (state_q != ST_DONE);

    buf_shift  = pop ? (buf_q << dec_len) : buf_q;
    fill_shift = pop ? (fill_q - {1'b0, dec_len}) : fill_q;
    buf_d      = buf_shift;
    fill_d     = fill_shift;
    // Bits below fill are always zero, so OR places the new word right after the survivors.
    if (push) begin
      buf_d  = buf_shift | ({i_data, {WORD_W{1'b0}}} >> fill_shift);
      fill_d = fill_shift + 7'd32;
    end

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_flush && !i_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!complete && (!o_valid_q || o_ready)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_RUN;
        buf_d   = '0;
        fill_d  = '0;
      end
      default: state_d = ST_RUN;
    endcase

    i_ready_d = (state_d == ST_RUN) && (fill_d <= 7'd32);

    o_valid_d = o_valid_q;
    enc_d     = enc_q;
    len_d     = len_q;
    pay_d     = pay_q;
    if (pop) begin
      o_valid_d = 1'b1;
      enc_d     = dec_enc;
      len_d     = dec_len;
      pay_d     = dec_payload;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RUN;
      buf_q     <= '0;
      fill_q    <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      enc_q     <= '0;
      len_q     <= '0;
      pay_q     <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
      enc_q     <= enc_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
    end
  end

  assign i_ready   = i_ready_q;
  assign o_valid   = o_valid_q;
  assign o_encoded = enc_q;
  assign o_length  = len_q;
  assign o_payload = pay_q;
  assign o_done    = (state_q == ST_DONE);

`ifdef WORD_LENGTH_DECODER_STATS_EN
  logic [15:0] wc_q, wc_d;

  always_comb begin
    wc_d = wc_q;
    if (o_valid_q && o_ready) wc_d = wc_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) wc_q <= '0;
    else       wc_q <= wc_d;
  end

  assign o_word_count = wc_q;
`endif

endmodule

// File: tb/tb_word_length_decoder.sv
// tb/tb_word_length_decoder.sv - scoreboard bench for word_length_decoder
module tb_word_length_decoder;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic        i_flush = 1'b0;
  logic [2:0]  o_encoded;
  logic [5:0]  o_length;
  logic [31:0] o_payload;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_done;
`ifdef WORD_LENGTH_DECODER_STATS_EN
  logic [15:0] o_word_count;
`endif

  always #5 clk = ~clk;

  word_length_decoder dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_flush   (i_flush),
    .o_encoded (o_encoded),
    .o_length  (o_length),
    .o_payload (o_payload),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_done    (o_done)
`ifdef WORD_LENGTH_DECODER_STATS_EN
    ,
    .o_word_count (o_word_count)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  bit          bp_window = 0;
  bit          bp_low = 0;
  bit          hold_pending = 0;
  logic [40:0] hold_val;
  logic [40:0] first_out;
  logic [15:0] hs_cnt = '0;
  bit          bits[$];
  logic [40:0] exp_q[$];
  logic [40:0] cur;

  assign cur = {o_encoded, o_length, o_payload};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] d);
    logic [2:0]  enc;
    int          len;
    int          pw;
    logic [31:0] pay;
    for (int b = 31; b >= 0; b--) bits.push_back(d[b]);
    forever begin
      enc = 3'd0; len = 2; pw = 0;
      if (bits.size() < 2) break;
      if (!bits[0]) begin
        if (bits[1]) begin enc = 3'd1; len = 6; pw = 4; end
      end else begin
        if (bits.size() < 3) break;
        case ({bits[1], bits[2]})
          2'b00:   begin enc = 3'd2; len = 12; pw = 9;  end
          2'b01:   begin enc = 3'd3; len = 16; pw = 13; end
          2'b10:   begin enc = 3'd4; len = 24; pw = 21; end
          default: begin enc = 3'd5; len = 34; pw = 31; end
        endcase
      end
      if (bits.size() < len) break;
      pay = '0;
      for (int i = len - pw; i < len; i++) pay = {pay[30:0], bits[i]};
      for (int i = 0; i < len; i++) void'(bits.pop_front());
      exp_q.push_back({enc, 6'(len), pay});
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = 1'($urandom_range(0, 1));
      default: o_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (i_rst) begin
      bits.delete();
      exp_q.delete();
      hold_pending = 0;
      hs_cnt = '0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", o_valid, 1);
        if (o_valid) check("hold_fields", cur, hold_val);
      end
      if (o_valid && o_ready) begin
        hs_cnt++;
        out_cnt++;
        if (out_cnt == 1) first_out = cur;
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("out", cur, exp_q.pop_front());
      end
      hold_pending = o_valid && !o_ready;
      hold_val = cur;
      if (i_valid && i_ready) model_push(i_data);
      if (o_done) begin
        done_cnt++;
        check("drain_complete", exp_q.size(), 0);
        bits.delete();
      end
      if (bp_window && !i_ready) bp_low = 1;
    end
  end

  task automatic send_word(input logic [31:0] d);
    bit ok;
    ok = 0;
    i_data = d;
    i_valid = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic do_flush();
    int d0;
    d0 = done_cnt;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse", done_cnt - d0, 1);
  endtask

  task automatic start_test();
    out_cnt = 0;
    done_cnt = 0;
    first_out = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_done", o_done, 0);
    check("rst_o_encoded", o_encoded, 0);
    check("rst_o_length", o_length, 0);
    check("rst_o_payload", o_payload, 0);
    check("rst_i_ready", i_ready, 1);
    check("rst_fill", dut.fill_q, 0);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    start_test();
    send_word(32'h0000_0000);
    do_flush();
    check("zeros_count", out_cnt, 16);
    check("zeros_first", first_out, {3'd0, 6'd2, 32'h0});

    start_test();
    send_word(32'hFFFF_FFFF);
    send_word(32'hC000_0000);
    do_flush();
    check("long_count", out_cnt, 16);
    check("long_first", first_out, {3'd5, 6'd34, 32'h7FFF_FFFF});

    start_test();
    send_word(32'h5C00_0000);
    do_flush();
    check("short_count", out_cnt, 14);
    check("short_first", first_out, {3'd1, 6'd6, 32'h7});

    start_test();
    send_word(32'hFFFF_FFFF);
    do_flush();
    check("partial_count", out_cnt, 0);
    check("partial_fill", dut.fill_q, 0);
    check("partial_i_ready", i_ready, 1);

    start_test();
    bp_low = 0;
    bp_window = 1;
    fork
      begin
        for (int w = 0; w < 4; w++) send_word(32'h0000_0000);
      end
      begin
        ready_mode = 2;
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    bp_window = 0;
    do_flush();
    check("bp_count", out_cnt, 64);
    check("bp_i_ready_fell", bp_low, 1);

    start_test();
    ready_mode = 1;
    for (int w = 0; w < 24; w++) send_word($urandom);
    do_flush();
    ready_mode = 0;
    check("rand_fill", dut.fill_q, 0);

    start_test();
    send_word(32'h0000_0000);
    for (int k = 0; k < 20 && !o_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_valid_seen", o_valid, 1);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_o_valid", o_valid, 0);
    check("rst_mid_fill", dut.fill_q, 0);
    check("rst_mid_i_ready", i_ready, 1);
    i_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_quiet", o_valid, 0);

    start_test();
    send_word(32'h8010_0000);
    do_flush();
    check("c100_first", first_out, {3'd2, 6'd12, 32'h1});

`ifdef WORD_LENGTH_DECODER_STATS_EN
    check("word_count", o_word_count, hs_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
